// File: rtl/udp_sweep_capture_pkg.sv
// Shared types and constants for the udp_sweep_capture stimulus/capture stage.
package udp_sweep_pkg;

  localparam int VEC_COUNT = 16;

  localparam logic [VEC_COUNT-1:0] EXP_E_DEFAULT = 16'hF333;
  localparam logic [VEC_COUNT-1:0] EXP_F_DEFAULT = 16'hA222;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    SAMPLE = 2'd2,
    FIN    = 2'd3
  } sweep_state_e;

endpackage

// File: rtl/udp_sweep_capture_if.sv
// Control, stimulus and capture signals between the sweep engine and its environment.
interface udp_sweep_capture_if;
  import udp_sweep_pkg::*;

  // start is a request sampled on the rising edge while the engine is not sweeping;
  // it is never queued. done is a one-cycle completion strobe, and maps/pass are
  // valid while done is high and hold until the next accepted start.
  logic                 start;
  logic                 a;
  logic                 b;
  logic                 c;
  logic                 d;
  logic                 e;
  logic                 f;
  logic                 busy;
  logic                 done;
  logic [VEC_COUNT-1:0] e_map;
  logic [VEC_COUNT-1:0] f_map;
  logic                 pass;
  sweep_state_e         state;

  modport master (
    input  start, e, f,
    output a, b, c, d, busy, done, e_map, f_map, pass, state
  );

  modport slave (
    output start, e, f,
    input  a, b, c, d, busy, done, e_map, f_map, pass, state
  );

endinterface

// File: rtl/udp_sweep_capture_cmp.sv
// Golden-map comparator: asserts match_o when both captured maps equal the expected maps.
module udp_sweep_cmp
  import udp_sweep_pkg::*;
#(
  parameter logic [VEC_COUNT-1:0] EXPECT_E = EXP_E_DEFAULT,
  parameter logic [VEC_COUNT-1:0] EXPECT_F = EXP_F_DEFAULT
) (
  input  logic [VEC_COUNT-1:0] e_map_i,
  input  logic [VEC_COUNT-1:0] f_map_i,
  output logic                 match_o
);

  logic [VEC_COUNT-1:0] diff;

  always_comb begin
    diff    = (e_map_i ^ EXPECT_E) | (f_map_i ^ EXPECT_F);
    match_o = ~|diff;
  end

endmodule

// File: rtl/udp_sweep_capture.sv
// Drives abcd through vectors 0..15, holds each SETTLE_CYCLES, samples e/f into maps.
// Define UDP_SWEEP_COMPARE_EN to build the golden-map comparator that drives pass.
module udp_sweep_capture
  import udp_sweep_pkg::*;
#(
  parameter int unsigned          SETTLE_CYCLES = 2,
  parameter logic [VEC_COUNT-1:0] EXPECT_E      = EXP_E_DEFAULT,
  parameter logic [VEC_COUNT-1:0] EXPECT_F      = EXP_F_DEFAULT
) (
  input logic                 clk,
  input logic                 rst_n,
  udp_sweep_capture_if.master sw
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [3:0] LAST_IDX    = 4'(VEC_COUNT - 1);

  sweep_state_e         state_q;
  logic [3:0]           idx_q;
  logic [3:0]           cnt_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 pass_q;
  logic [VEC_COUNT-1:0] e_map_q;
  logic [VEC_COUNT-1:0] f_map_q;
  logic [VEC_COUNT-1:0] e_map_d;
  logic [VEC_COUNT-1:0] f_map_d;
  logic                 arm;
  logic                 cmp_match;

  // The FIN cycle doubles as the idle cycle, so a held start re-arms right after done.
  always_comb begin
    arm            = sw.start && ((state_q == IDLE) || (state_q == FIN));
    e_map_d        = e_map_q;
    f_map_d        = f_map_q;
    e_map_d[idx_q] = sw.e;
    f_map_d[idx_q] = sw.f;
  end

`ifdef UDP_SWEEP_COMPARE_EN
  // Fed with the next-state maps so pass lands on the same edge as done.
  udp_sweep_cmp #(
    .EXPECT_E (EXPECT_E),
    .EXPECT_F (EXPECT_F)
  ) u_cmp (
    .e_map_i (e_map_d),
    .f_map_i (f_map_d),
    .match_o (cmp_match)
  );
`else
  logic unused_expect;
  assign unused_expect = ^{EXPECT_E, EXPECT_F};
  assign cmp_match     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      e_map_q <= '0;
      f_map_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (arm) begin
        state_q <= WAIT;
        idx_q   <= '0;
        cnt_q   <= SETTLE_LOAD;
        busy_q  <= 1'b1;
        pass_q  <= 1'b0;
        e_map_q <= '0;
        f_map_q <= '0;
      end else begin
        case (state_q)
          IDLE: state_q <= IDLE;
          WAIT: begin
            if (cnt_q == '0) begin
              state_q <= SAMPLE;
            end else begin
              cnt_q <= cnt_q - 4'd1;
            end
          end
          SAMPLE: begin
            e_map_q <= e_map_d;
            f_map_q <= f_map_d;
            if (idx_q == LAST_IDX) begin
              state_q <= FIN;
              idx_q   <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= cmp_match;
            end else begin
              state_q <= WAIT;
              idx_q   <= idx_q + 4'd1;
              cnt_q   <= SETTLE_LOAD;
            end
          end
          FIN:     state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign sw.a     = idx_q[3];
  assign sw.b     = idx_q[2];
  assign sw.c     = idx_q[1];
  assign sw.d     = idx_q[0];
  assign sw.busy  = busy_q;
  assign sw.done  = done_q;
  assign sw.pass  = pass_q;
  assign sw.e_map = e_map_q;
  assign sw.f_map = f_map_q;
  assign sw.state = state_q;

endmodule

// File: tb/tb_udp_sweep_capture.sv
// Bench for udp_sweep_capture: an S=2 and an S=1 instance, each driving a modelled circuit.
module tb_udp_sweep_capture;
  import udp_sweep_pkg::*;

  localparam int W = 1 + 2 * VEC_COUNT;

  logic clk;
  logic rst_n;
  int   mode2;
  int   mode1;
  int   checks;
  int   errors;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_q1[$];

  udp_sweep_capture_if if2();
  udp_sweep_capture_if if1();

  udp_sweep_capture #(
    .SETTLE_CYCLES (2),
    .EXPECT_E      (EXP_E_DEFAULT),
    .EXPECT_F      (EXP_F_DEFAULT)
  ) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .sw    (if2.master)
  );

  udp_sweep_capture #(
    .SETTLE_CYCLES (1),
    .EXPECT_E      (EXP_E_DEFAULT),
    .EXPECT_F      (EXP_F_DEFAULT)
  ) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .sw    (if1.master)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- circuit under test models ----------------
  // mode 0: golden circuit; mode 1: e stuck at 0, f = e & d; other: e inverted, f = d
  function automatic logic [1:0] cut(input int mode, input logic [3:0] v);
    logic [15:0] ge;
    logic [15:0] gf;
    logic        ev;
    ge = EXP_E_DEFAULT;
    gf = EXP_F_DEFAULT;
    case (mode)
      0: cut = {ge[v], gf[v]};
      1: begin
        ev  = 1'b0;
        cut = {ev, ev & v[0]};
      end
      default: cut = {~ge[v], v[0]};
    endcase
  endfunction

  assign {if2.e, if2.f} = cut(mode2, {if2.a, if2.b, if2.c, if2.d});
  assign {if1.e, if1.f} = cut(mode1, {if1.a, if1.b, if1.c, if1.d});

  function automatic logic [W-1:0] entry(input int mode);
    logic [15:0] em;
    logic [15:0] fm;
    logic [1:0]  r;
    logic        p;
    for (int i = 0; i < VEC_COUNT; i++) begin
      r     = cut(mode, 4'(i));
      em[i] = r[1];
      fm[i] = r[0];
    end
`ifdef UDP_SWEEP_COMPARE_EN
    p = (em == EXP_E_DEFAULT) && (fm == EXP_F_DEFAULT);
`else
    p = 1'b0;
`endif
    return {p, em, fm};
  endfunction

  // ---------------- S=2 sweep driver + checks ----------------
  task automatic sweep2(input string name, input int mode, input int inject_at);
    logic [W-1:0] exp;
    logic [W-1:0] got;
    int           cyc;
    int           bad_vec;
    int           dones;
    logic [3:0]   vexp;
    mode2 = mode;
    exp_q.push_back(entry(mode));
    @(negedge clk); if2.start = 1'b1;
    @(negedge clk); if2.start = 1'b0;
    cyc     = 0;
    bad_vec = 0;
    while (!if2.done && cyc < 200) begin
      vexp = 4'(cyc / 3);
      if ({if2.a, if2.b, if2.c, if2.d} !== vexp || if2.busy !== 1'b1) bad_vec++;
      @(negedge clk);
      cyc++;
      if2.start = (cyc == inject_at);
    end
    if2.start = 1'b0;
    checks++;
    if (cyc !== 48) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles, expected 48", name, cyc);
    end
    checks++;
    if (bad_vec !== 0) begin
      errors++;
      $display("FAIL %s vec_order: %0d cycles with wrong abcd/busy, expected 0", name, bad_vec);
    end
    exp = exp_q.pop_front();
    got = {if2.pass, if2.e_map, if2.f_map};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s maps: got pass=%b e=%h f=%h, expected pass=%b e=%h f=%h",
               name, got[W-1], got[31:16], got[15:0], exp[W-1], exp[31:16], exp[15:0]);
    end
    checks++;
    if (if2.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_at_done: got %b, expected 0", name, if2.busy);
    end
    @(negedge clk);
    checks++;
    if (if2.done !== 1'b0 || if2.state !== IDLE) begin
      errors++;
      $display("FAIL %s back_to_idle: got done=%b state=%0d, expected done=0 state=0",
               name, if2.done, if2.state);
    end
    dones = 0;
    repeat (20) begin
      @(negedge clk);
      if (if2.done) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL %s single_done: got %0d extra done pulses, expected 0", name, dones);
    end
    checks++;
    if ({if2.pass, if2.e_map, if2.f_map} !== exp || {if2.a, if2.b, if2.c, if2.d} !== 4'd0) begin
      errors++;
      $display("FAIL %s idle_hold: got pass=%b e=%h f=%h abcd=%h, expected pass=%b e=%h f=%h abcd=0",
               name, if2.pass, if2.e_map, if2.f_map, {if2.a, if2.b, if2.c, if2.d},
               exp[W-1], exp[31:16], exp[15:0]);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n     = 1'b1;
    if2.start = 1'b0;
    if1.start = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if ({if2.busy, if2.done, if2.pass, if2.a, if2.b, if2.c, if2.d} !== 7'd0 ||
        if2.e_map !== 16'd0 || if2.f_map !== 16'd0 || if2.state !== IDLE) begin
      errors++;
      $display("FAIL reset_dut2: got busy=%b done=%b pass=%b e=%h f=%h state=%0d, expected all 0",
               if2.busy, if2.done, if2.pass, if2.e_map, if2.f_map, if2.state);
    end
    checks++;
    if ({if1.busy, if1.done, if1.pass, if1.a, if1.b, if1.c, if1.d} !== 7'd0 ||
        if1.e_map !== 16'd0 || if1.f_map !== 16'd0 || if1.state !== IDLE) begin
      errors++;
      $display("FAIL reset_dut1: got busy=%b done=%b pass=%b e=%h f=%h state=%0d, expected all 0",
               if1.busy, if1.done, if1.pass, if1.e_map, if1.f_map, if1.state);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_golden();
    sweep2("golden", 0, -1);
    checks++;
    if (if2.e_map !== 16'hF333 || if2.f_map !== 16'hA222) begin
      errors++;
      $display("FAIL golden_const: got e=%h f=%h, expected e=f333 f=a222", if2.e_map, if2.f_map);
    end
  endtask

  task automatic test_fault();
    sweep2("fault", 1, -1);
  endtask

  task automatic test_start_during_busy();
    sweep2("start_busy", 2, 10);
  endtask

  task automatic test_held_start();
    int           modes[3];
    int           cyc;
    int           last;
    logic [W-1:0] exp;
    logic [W-1:0] got;
    modes = '{0, 2, 1};
    mode1 = modes[0];
    exp_q1.push_back(entry(modes[0]));
    @(negedge clk); if1.start = 1'b1;
    @(negedge clk);
    cyc  = 0;
    last = 0;
    for (int s = 0; s < 3; s++) begin
      while (!if1.done && (cyc - last) < 100) begin
        @(negedge clk);
        cyc++;
      end
      checks++;
      if ((cyc - last) !== ((s == 0) ? 32 : 33)) begin
        errors++;
        $display("FAIL held_period%0d: got %0d cycles, expected %0d", s, cyc - last, (s == 0) ? 32 : 33);
      end
      last = cyc;
      exp  = exp_q1.pop_front();
      got  = {if1.pass, if1.e_map, if1.f_map};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL held_maps%0d: got pass=%b e=%h f=%h, expected pass=%b e=%h f=%h",
                 s, got[W-1], got[31:16], got[15:0], exp[W-1], exp[31:16], exp[15:0]);
      end
      if (s < 2) begin
        mode1 = modes[s+1];
        exp_q1.push_back(entry(modes[s+1]));
        @(negedge clk);
        cyc++;
        checks++;
        if (if1.busy !== 1'b1 || if1.e_map !== 16'd0 || if1.f_map !== 16'd0 || if1.pass !== 1'b0) begin
          errors++;
          $display("FAIL held_restart%0d: got busy=%b e=%h f=%h pass=%b, expected busy=1 maps 0 pass=0",
                   s, if1.busy, if1.e_map, if1.f_map, if1.pass);
        end
      end else begin
        if1.start = 1'b0;
        @(negedge clk);
        checks++;
        if (if1.state !== IDLE || if1.busy !== 1'b0) begin
          errors++;
          $display("FAIL held_release: got state=%0d busy=%b, expected state=0 busy=0", if1.state, if1.busy);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int dones;
    mode2 = 0;
    @(negedge clk); if2.start = 1'b1;
    @(negedge clk); if2.start = 1'b0;
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({if2.busy, if2.done, if2.pass, if2.a, if2.b, if2.c, if2.d} !== 7'd0 ||
        if2.e_map !== 16'd0 || if2.f_map !== 16'd0 || if2.state !== IDLE) begin
      errors++;
      $display("FAIL reset_mid: got busy=%b abcd=%h e=%h f=%h state=%0d, expected all 0",
               if2.busy, {if2.a, if2.b, if2.c, if2.d}, if2.e_map, if2.f_map, if2.state);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (60) begin
      @(negedge clk);
      if (if2.done || if1.done) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL reset_no_done: got %0d done pulses, expected 0", dones);
    end
    sweep2("after_reset", 0, -1);
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    checks = 0;
    errors = 0;
    mode2  = 0;
    mode1  = 0;
    test_reset();
    test_golden();
    test_fault();
    test_start_during_busy();
    test_held_start();
    test_reset_mid();
    checks++;
    if (exp_q.size() !== 0 || exp_q1.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d/%0d entries left, expected 0/0", exp_q.size(), exp_q1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/udp_sweep_capture.md
# udp_sweep_capture

Upstream stimulus-and-capture stage for the 4-input truth-table circuit (outputs `e`, `f` from inputs `a`, `b`, `c`, `d`). On `start` it drives all 16 input combinations in ascending order and waits a programmable settle time per vector. It then samples `e`/`f` into two 16-bit maps, compares them against expected maps and reports completion. It is used on the lab board and in benches to characterise the circuit without manual switching.

## Interface
- `SETTLE_CYCLES`, default 2: cycles each vector is held before sampling; legal range 1..15.
- `EXPECT_E`, default 16'hF333: golden `e` map, bit i = response to vector i.
- `EXPECT_F`, default 16'hA222: golden `f` map.
- `clk` in 1: single clock; all logic on rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `start` in 1: request a sweep; accepted only in IDLE.
- `a`, `b`, `c`, `d` out 1 each: registered stimulus; vector index i = {a,b,c,d}, with `a` as MSB.
- `e`, `f` in 1 each: responses of the circuit under test.
- `busy` out 1: sweep in progress.
- `done` out 1: one-cycle pulse when the sweep completes.
- `e_map`, `f_map` out 16 each: captured responses, bit i = sample for vector i.
- `pass` out 1: maps equal expected values; valid while `done` is high and held until the next start.

## Operation
- FSM states:
  - IDLE: outputs quiescent. `start`=1 → WAIT. Entry actions: idx=0, abcd=0000, settle count loaded, both maps cleared, `pass` cleared.
  - WAIT: the counter runs for exactly SETTLE_CYCLES cycles, then → SAMPLE.
  - SAMPLE: on the closing edge, `e`→`e_map[idx]` and `f`→`f_map[idx]`.
    - idx<15: idx+1, new vector driven, → WAIT.
    - idx=15: → FIN.
  - FIN: `done`=1 for one cycle, `pass` updated, → IDLE.
- idx is a 4-bit counter. It never wraps inside a sweep, because idx=15 exits to FIN.
- `start` outside IDLE is ignored and not queued. `start` held high continuously re-arms a new sweep from IDLE, the cycle after FIN.
- Maps and `pass` hold their values in IDLE until the next accepted start.
- Asynchronous reset mid-sweep aborts the sweep; all outputs return to reset values immediately.

## Timing
- Reset values: state IDLE, `a`=`b`=`c`=`d`=0, `busy`=0, `done`=0, `e_map`=`f_map`=0, `pass`=0.
- Start accepted at edge 0. `busy` and vector 0 are visible after edge 0.
- Vector k is driven after edge k·(S+1) and sampled at edge (k+1)·(S+1), with S=SETTLE_CYCLES.
- After edge 16·(S+1): `busy`=0 and `done`=1 for one cycle; FSM back in IDLE one edge later.
- Total latency is 16·(S+1) cycles from the accepting edge: 48 cycles at the default setting.
- `e`/`f` are sampled synchronously. The circuit under test must settle within S cycles of the vector change.

## Configuration
- `UDP_SWEEP_COMPARE_EN`:
  - Defined: comparator instantiated; at FIN, `pass` = (`e_map`==`EXPECT_E`) && (`f_map`==`EXPECT_F`).
  - Undefined: no comparator, `pass` tied to 0, `EXPECT_*` unused.
  - Maps, handshake and timing are identical in both builds.

## Structure
- Package `udp_sweep_pkg` holds:
  - FSM state enum (IDLE, WAIT, SAMPLE, FIN).
  - `VEC_COUNT`=16.
  - Default golden constants `EXP_E_DEFAULT`=16'hF333 and `EXP_F_DEFAULT`=16'hA222.
- One sub-module: `udp_sweep_cmp`, the map comparator, instantiated only under `UDP_SWEEP_COMPARE_EN`. Counter and FSM stay in the top module.

## Test plan
- Reset: assert `rst_n`=0 mid-operation → all outputs at reset values in the same cycle; no `done` pulse afterwards.
- Golden sweep (S=2, correct circuit attached): pulse `start` → `done` after exactly 48 cycles, `e_map`=16'hF333, `f_map`=16'hA222, `pass`=1; abcd visits 0..15 in order, each held 3 cycles.
- Fault: tie `e` to 0, with `f`=e&d → `e_map`=0, `f_map`=0, `pass`=0; with the macro undefined, `pass`=0 regardless.
- Start during busy: pulse `start` at cycle 10 → ignored; `done` still at cycle 48, and exactly one `done` pulse.
- S=1, `start` held high → `done` every 33 cycles (32 sweep + 1 IDLE); maps cleared at each restart, confirmed by toggling `e` behaviour between sweeps.
- Reset at cycle 20 then new `start` → fresh sweep from vector 0, maps start at 0, `done` at 48 cycles after the new start.
